keypad_emulator: RTL and testbench

Synthesizable far-end model of the 3×4 keypad matrix used by the tic-tac-toe board. It sits on the `key_col`/`key_row` pins in place of the physical keypad and answers the column scan by driving row lines for queued key codes. Each key is held for a fixed time and then released for a fixed gap, so scripted move sequences can be replayed into the unmodified scanner for demo and self-test.

---
 rtl/keypad_pkg.sv | 63 ++++++
 rtl/keypad_emulator_fifo.sv | 46 ++++
 rtl/keypad_emulator.sv | 122 ++++++++++++
 tb/tb_keypad_emulator.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes, column strobes, FSM states and matrix map
// for the keypad emulator.
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  localparam logic [2:0] NO_SCAN = 3'b000;
  localparam logic [2:0] COLUMN1 = 3'b001;
  localparam logic [2:0] COLUMN2 = 3'b010;
  localparam logic [2:0] COLUMN3 = 3'b100;

  localparam logic [3:0] ROW0 = 4'b0001;
  localparam logic [3:0] ROW1 = 4'b0010;
  localparam logic [3:0] ROW2 = 4'b0100;
  localparam logic [3:0] ROW3 = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_COL,
    ST_HOLD,
    ST_GAP
  } state_t;

  function automatic logic is_legal(input logic [3:0] code);
    return code <= KEY_HASH;
  endfunction

  // Illegal codes map to NO_SCAN so they can never match a column strobe.
  function automatic logic [2:0] col_of(input logic [3:0] code);
    logic [2:0] col;
    case (code)
      KEY_1, KEY_4, KEY_7, KEY_STAR: col = COLUMN1;
      KEY_2, KEY_5, KEY_8, KEY_0:    col = COLUMN2;
      KEY_3, KEY_6, KEY_9, KEY_HASH: col = COLUMN3;
      default:                       col = NO_SCAN;
    endcase
    return col;
  endfunction

  function automatic logic [3:0] row_of(input logic [3:0] code);
    logic [3:0] row;
    case (code)
      KEY_1, KEY_2, KEY_3:           row = ROW0;
      KEY_4, KEY_5, KEY_6:           row = ROW1;
      KEY_7, KEY_8, KEY_9:           row = ROW2;
      KEY_STAR, KEY_0, KEY_HASH:     row = ROW3;
      default:                       row = 4'b0000;
    endcase
    return row;
  endfunction

endpackage

// File: rtl/keypad_emulator_fifo.sv
// rtl/keypad_emulator_fifo.sv - key_fifo: small synchronous FIFO holding queued key codes.
// DEPTH must be a power of two, at least 2.
module key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - far-end 3x4 keypad model answering the column scan with
// row returns for queued key codes, each held then released for fixed times.
module keypad_emulator #(
  parameter int HOLD_CYCLES = 75000,
  parameter int GAP_CYCLES  = 75000,
  parameter int DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_col,
  output logic [3:0] key_row,
  input  logic [3:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       busy,
  output logic [3:0] active_key,
  output logic       err
);

  import keypad_pkg::*;

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    active_n;
  logic [3:0]    row_n;
  logic          col_match;
  logic          fifo_pop;
  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [3:0]    fifo_dout;
  logic          accept;

  assign key_ready = !fifo_full;
  assign accept    = key_valid && key_ready;
  assign fifo_push = accept && is_legal(key_in);

  key_fifo #(
    .WIDTH (4),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (key_in),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Non-one-hot strobes never equal a column constant, so they read as no match.
  assign col_match = (key_col == col_of(active_key));

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    active_n = active_key;
    fifo_pop = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          active_n = fifo_dout;
          state_n  = ST_WAIT_COL;
        end
      end
      ST_WAIT_COL: begin
        if (col_match) begin
          state_n = ST_HOLD;
          cnt_n   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_n = ST_GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Row drive follows the next state so the press spans exactly HOLD_CYCLES edges.
  always_comb begin
    row_n = 4'b0000;
    if (state_n == ST_HOLD && col_match) row_n = row_of(active_key);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      active_key <= 4'd0;
      key_row    <= 4'b0000;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      active_key <= active_n;
      key_row    <= row_n;
      busy       <= (state_n != ST_IDLE);
      err        <= accept && !is_legal(key_in);
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - self-checking bench for keypad_emulator with a
// rotating, row-freezing column scanner model.
module tb_keypad_emulator;

  localparam int HOLD = 8;
  localparam int GAP  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_col;
  logic [3:0] key_row;
  logic [3:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic       busy;
  logic [3:0] active_key;
  logic       err;

  logic       rot_en;
  logic [2:0] rot_col = 3'b001;
  logic [2:0] forced_col;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] code;
    logic [2:0] col;
    logic [3:0] row;
    logic       bad;
  } vec_t;

  vec_t vecs [8];

  keypad_emulator #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .DEPTH       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_col    (key_col),
    .key_row    (key_row),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .active_key (active_key),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Scanner: rotates its strobe each cycle, frozen while any row is returned.
  assign key_col = rot_en ? rot_col : forced_col;
  always @(negedge clk) begin
    if (rot_en && key_row == 4'd0) rot_col <= {rot_col[1:0], rot_col[2]};
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_row(input logic [3:0] c);
    case (c)
      4'd1, 4'd2, 4'd3:   return 4'b0001;
      4'd4, 4'd5, 4'd6:   return 4'b0010;
      4'd7, 4'd8, 4'd9:   return 4'b0100;
      4'd0, 4'd10, 4'd11: return 4'b1000;
      default:            return 4'b0000;
    endcase
  endfunction

  task automatic push(input logic [3:0] c);
    @(negedge clk);
    key_in    = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_row(input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      if (key_row != 4'd0) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while (busy && k < max) begin
      k++;
      @(negedge clk);
    end
  endtask

  // Entered at the first negedge showing the pressed row; leaves with busy low.
  task automatic measure(input logic [3:0] row, output int hi, output int gap, output int bad);
    hi = 0;
    while (key_row == row && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    gap = 0;
    bad = 0;
    while (busy && gap < 50) begin
      if (key_row != 4'd0) bad++;
      gap++;
      @(negedge clk);
    end
  endtask

  initial begin
    bit         ok;
    int         hi, gap, bad, nz, n_ev;
    logic [3:0] prev;
    logic [3:0] ev_row [8];
    logic [2:0] ev_col [8];
    logic [3:0] ev_key [8];
    logic [3:0] drain_exp [5];

    vecs[0] = '{4'd5,  3'b010, 4'b0010, 1'b0};
    vecs[1] = '{4'd1,  3'b001, 4'b0001, 1'b0};
    vecs[2] = '{4'd0,  3'b010, 4'b1000, 1'b0};
    vecs[3] = '{4'd10, 3'b001, 4'b1000, 1'b0};
    vecs[4] = '{4'd13, 3'b000, 4'b0000, 1'b1};
    vecs[5] = '{4'd11, 3'b100, 4'b1000, 1'b0};
    vecs[6] = '{4'd9,  3'b100, 4'b0100, 1'b0};
    vecs[7] = '{4'd15, 3'b000, 4'b0000, 1'b1};

    rst        = 1'b1;
    key_in     = 4'd0;
    key_valid  = 1'b0;
    rot_en     = 1'b0;
    forced_col = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_key_row", key_row, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_active_key", active_key, 4'd0);
    check("rst_err", err, 1'b0);
    check("rst_key_ready", key_ready, 1'b1);
    rst = 1'b0;

    rot_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].code);
      if (vecs[i].bad) begin
        check("vec_err_pulse", err, 1'b1);
        @(negedge clk);
        check("vec_err_single", err, 1'b0);
        repeat (3) @(negedge clk);
        check("vec_err_busy", busy, 1'b0);
        check("vec_err_ready", key_ready, 1'b1);
        check("vec_err_row", key_row, 4'd0);
      end else begin
        wait_row(20, ok);
        check("vec_row_seen", ok, 1'b1);
        if (ok) begin
          check("vec_row", key_row, vecs[i].row);
          check("vec_col", key_col, vecs[i].col);
          check("vec_active_key", active_key, vecs[i].code);
          measure(vecs[i].row, hi, gap, bad);
          check("vec_hold_len", hi, HOLD);
          check("vec_gap_len", gap, GAP);
          check("vec_gap_rows", bad, 0);
        end else begin
          wait_idle(50);
        end
      end
    end

    // Pop-to-row latency with a steady col2 strobe.
    rot_en     = 1'b0;
    forced_col = 3'b010;
    @(negedge clk);
    key_in    = 4'd5;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("lat_push_row", key_row, 4'd0);
    check("lat_push_busy", busy, 1'b0);
    @(negedge clk);
    check("lat_pop_busy", busy, 1'b1);
    check("lat_pop_row", key_row, 4'd0);
    check("lat_pop_key", active_key, 4'd5);
    @(negedge clk);
    check("lat_first_row", key_row, 4'b0010);
    measure(4'b0010, hi, gap, bad);
    check("lat_hold_len", hi, HOLD);
    check("lat_gap_len", gap, GAP);

    // Back-to-back 1, 9, #: queued while the scan is parked, then replayed.
    forced_col = 3'b000;
    push(4'd1);
    push(4'd9);
    push(4'd11);
    rot_en = 1'b1;
    n_ev   = 0;
    prev   = 4'd0;
    for (int k = 0; k < 400 && !(n_ev == 3 && !busy); k++) begin
      if (key_row != 4'd0 && prev == 4'd0 && n_ev < 8) begin
        ev_row[n_ev] = key_row;
        ev_col[n_ev] = key_col;
        n_ev++;
      end
      prev = key_row;
      @(negedge clk);
    end
    check("b2b_events", n_ev, 3);
    if (n_ev >= 3) begin
      check("b2b_row0", ev_row[0], 4'b0001);
      check("b2b_col0", ev_col[0], 3'b001);
      check("b2b_row1", ev_row[1], 4'b0100);
      check("b2b_col1", ev_col[1], 3'b100);
      check("b2b_row2", ev_row[2], 4'b1000);
      check("b2b_col2", ev_col[2], 3'b100);
    end

    // Stuck in WAIT_COL: one key active, four queued, fifth held off.
    rot_en     = 1'b0;
    forced_col = 3'b000;
    push(4'd3);
    push(4'd2);
    push(4'd4);
    push(4'd6);
    push(4'd8);
    check("full_ready_low", key_ready, 1'b0);
    @(negedge clk);
    key_in    = 4'd0;
    key_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("full_held_off", key_ready, 1'b0);
    check("full_row_idle", key_row, 4'd0);
    check("full_active", active_key, 4'd3);
    check("full_busy", busy, 1'b1);
    key_valid = 1'b0;
    drain_exp[0] = 4'd3;
    drain_exp[1] = 4'd2;
    drain_exp[2] = 4'd4;
    drain_exp[3] = 4'd6;
    drain_exp[4] = 4'd8;
    rot_en = 1'b1;
    n_ev   = 0;
    prev   = 4'd0;
    for (int k = 0; k < 600 && !(n_ev == 5 && !busy); k++) begin
      if (key_row != 4'd0 && prev == 4'd0 && n_ev < 8) begin
        ev_key[n_ev] = active_key;
        ev_row[n_ev] = key_row;
        n_ev++;
      end
      prev = key_row;
      @(negedge clk);
    end
    check("drain_events", n_ev, 5);
    for (int j = 0; j < 5; j++) begin
      if (j < n_ev) begin
        check("drain_order", ev_key[j], drain_exp[j]);
        check("drain_row", ev_row[j], exp_row(drain_exp[j]));
      end
    end
    check("drain_ready", key_ready, 1'b1);

    // Key 7 waits through a long col3 strobe, then answers col1 one edge later.
    rot_en     = 1'b0;
    forced_col = 3'b100;
    push(4'd7);
    nz = 0;
    repeat (20) begin
      @(negedge clk);
      if (key_row != 4'd0) nz++;
    end
    check("wait_col_no_row", nz, 0);
    forced_col = 3'b001;
    @(negedge clk);
    check("wait_col_match_row", key_row, 4'b0100);
    measure(4'b0100, hi, gap, bad);
    check("wait_col_hold_len", hi, HOLD);

    // Reset in the middle of a press with two codes queued.
    forced_col = 3'b000;
    push(4'd1);
    push(4'd2);
    push(4'd3);
    forced_col = 3'b001;
    wait_row(10, ok);
    check("rst_mid_pressed", ok, 1'b1);
    repeat (2) @(negedge clk);
    check("rst_mid_row_before", key_row, 4'b0001);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_row_async", key_row, 4'd0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ready", key_ready, 1'b1);
    check("rst_mid_active", active_key, 4'd0);
    @(negedge clk);
    rst    = 1'b0;
    rot_en = 1'b1;
    nz     = 0;
    bad    = 0;
    repeat (40) begin
      @(negedge clk);
      if (key_row != 4'd0) nz++;
      if (busy) bad++;
    end
    check("rst_after_no_press", nz, 0);
    check("rst_after_no_busy", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
